// File: rtl/vchip8_pkg.sv
// Shared constants for the switch debounce block and the switch PIO wrapper.
package vchip8_pkg;

  localparam int SWITCH_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
  localparam int SWITCH_WIDTH           = 2;

endpackage

// File: rtl/vchip8_debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter, clean level flop
// and registered single-cycle rise/fall pulses.
module vchip8_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic             rise_q, fall_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Any sample equal to the clean level restarts the count, so glitches
  // never accumulate partial progress.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    accept  = 1'b0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_MAX) begin
        accept  = 1'b1;
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= accept & sync2_q;
      fall_q  <= accept & ~sync2_q;
    end
  end

  assign clean_o  = clean_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign accept_o = accept;

endmodule

// File: rtl/vchip8_switch_debounce.sv
// Debounces the board slide switches ahead of the switch PIO and provides
// registered per-bit edge pulses plus a combined change strobe.
module vchip8_switch_debounce
  import vchip8_pkg::*;
#(
  parameter int WIDTH           = SWITCH_WIDTH,
  parameter int DEBOUNCE_CYCLES = SWITCH_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  logic [WIDTH-1:0] accept;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    vchip8_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw_i    (switch_raw[i]),
      .clean_o  (switch_clean[i]),
      .rise_o   (rise_pulse[i]),
      .fall_o   (fall_pulse[i]),
      .accept_o (accept[i])
    );
  end

  // Registered from the same acceptance terms as the pulses so it lines up
  // with them in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) changed_q <= 1'b0;
    else          changed_q <= |accept;
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_vchip8_switch_debounce.sv
// Scoreboard bench for vchip8_switch_debounce with DEBOUNCE_CYCLES=4, WIDTH=2.
module tb_vchip8_switch_debounce;

  localparam int D = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] switch_raw;
  logic [W-1:0] switch_clean, rise_pulse, fall_pulse;
  logic         changed;

  typedef struct {
    int           at_edge;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } ev_t;

  ev_t          sb_q[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  int           edge_n = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] exp_clean = '0;

  vchip8_switch_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .switch_raw   (switch_raw),
    .switch_clean (switch_clean),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .changed      (changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int at, input logic [W-1:0] c, input logic [W-1:0] r,
                      input logic [W-1:0] f);
    ev_t ev;
    ev.at_edge = at;
    ev.clean   = c;
    ev.rise    = r;
    ev.fall    = f;
    sb_q.push_back(ev);
  endtask

  // Called at a falling edge: the new raw value is first sampled at edge k.
  task automatic drive(input logic [W-1:0] v, output int k);
    switch_raw = v;
    k = edge_n + 1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({switch_clean, rise_pulse, fall_pulse, changed});
  endfunction

  // Every monitored edge: either the scheduled event or a steady state.
  initial begin
    forever begin
      ev_t          ev;
      logic [W-1:0] er, ef;
      @(posedge clk);
      edge_n++;
      #1;
      if (mon_en) begin
        er = '0;
        ef = '0;
        while (sb_q.size() > 0 && sb_q[0].at_edge < edge_n) begin
          ev = sb_q.pop_front();
          chk("sb_missed_event", 32'(edge_n), 32'(ev.at_edge));
        end
        if (sb_q.size() > 0 && sb_q[0].at_edge == edge_n) begin
          ev = sb_q.pop_front();
          exp_clean = ev.clean;
          er = ev.rise;
          ef = ev.fall;
        end
        chk($sformatf("outs@%0d", edge_n), outs(),
            32'({exp_clean, er, ef, |(er | ef)}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int k2;
    reset_n    = 1'b0;
    switch_raw = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 32'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (20) @(negedge clk);

    // single bit rise
    drive(2'b01, k);
    push(k + 5, 2'b01, 2'b01, 2'b00);
    repeat (10) @(negedge clk);

    // bit1 glitch of 3 cycles rejected
    drive(2'b11, k);
    repeat (3) @(negedge clk);
    drive(2'b01, k);
    repeat (10) @(negedge clk);

    // bit1 high for 5 cycles: accepted, then the return low is accepted too
    drive(2'b11, k);
    push(k + 5, 2'b11, 2'b10, 2'b00);
    repeat (5) @(negedge clk);
    drive(2'b01, k2);
    push(k2 + 5, 2'b01, 2'b00, 2'b10);
    repeat (12) @(negedge clk);

    // both bits flip in the same cycle
    drive(2'b10, k);
    push(k + 5, 2'b10, 2'b10, 2'b01);
    repeat (10) @(negedge clk);

    // bit0 chatter every 2 cycles, ending high
    for (int s = 0; s < 15; s++) begin
      drive((s % 2 == 0) ? 2'b11 : 2'b10, k);
      repeat (2) @(negedge clk);
    end
    push(k + 5, 2'b11, 2'b01, 2'b00);
    repeat (10) @(negedge clk);

    // both low, then reset while bit0 counter sits at 3
    drive(2'b00, k);
    push(k + 5, 2'b00, 2'b00, 2'b11);
    repeat (10) @(negedge clk);
    drive(2'b01, k);
    repeat (5) @(negedge clk);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_count", outs(), 32'h0);
    repeat (3) @(negedge clk);
    chk("reset_held", outs(), 32'h0);
    sb_q.delete();
    exp_clean = '0;
    reset_n   = 1'b1;
    k = edge_n + 1;
    push(k + 5, 2'b01, 2'b01, 2'b00);
    mon_en = 1'b1;
    repeat (12) @(negedge clk);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
